ifu_prefetch: RTL and testbench

//  Parametrised multi-cycle instruction fetch unit with prefetch FIFO.

---
 rtl/ifu_prefetch.sv | 125 ++++++++++++
 tb/tb_ifu_prefetch.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: one-outstanding-request fetch FSM feeding a small prefetch FIFO
// toward decode, with redirect flush and stale-response drop.
module ifu_prefetch #(
  parameter int unsigned    XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000,
  parameter int unsigned    FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  input  logic            rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StReq, StWait, StDrop, StHalt} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic [XLEN-1:0] inst_mem_q [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem_q   [FIFO_DEPTH];
  logic            err_mem_q  [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_after_pop;

  logic            push, pop, credit, req_fire;
  logic [XLEN-1:0] redirect_target;
  logic            unused_pc_bits;

  assign unused_pc_bits  = ^redirect_pc[1:0];
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  assign inst_valid = !rst && (count_q != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst       = inst_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign inst_err   = err_mem_q[rd_ptr_q];

  // A pop in this cycle frees a slot, so it counts toward credit immediately.
  assign count_after_pop = count_q - CntW'(pop);
  assign credit          = count_after_pop < CntW'(FIFO_DEPTH);

  assign req_valid = !rst && (state_q == StReq) && credit;
  assign req_addr  = fetch_pc_q;
  assign req_fire  = req_valid && req_ready;

  assign push = (state_q == StWait) && rsp_valid && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    unique case (state_q)
      StReq: begin
        if (req_fire) begin
          state_d    = StWait;
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          req_pc_d   = fetch_pc_q;
        end
      end
      StWait:  if (rsp_valid) state_d = rsp_err ? StHalt : StReq;
      StDrop:  if (rsp_valid) state_d = StReq;
      StHalt:  state_d = StHalt;
      default: state_d = StReq;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      unique case (state_q)
        StReq:          state_d = req_fire ? StDrop : StReq;
        // A response arriving this cycle settles the one owed; otherwise it is still stale.
        StWait, StDrop: state_d = rsp_valid ? StReq : StDrop;
        default:        state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StReq;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      if (redirect_valid) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= rsp_data;
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
      err_mem_q[wr_ptr_q]  <= rsp_err;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: behavioural memory responder, pop monitor and
// hand-computed expectations for fetch order, back-pressure, redirect, fault and wrap.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        rsp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;

  int n_checks = 0;
  int n_errors = 0;
  int lat = 1;
  logic [31:0] err_addr = 32'h0000_0001;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
  } ent_t;
  ent_t q[$];

  ifu_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_q(input int n);
    for (int i = 0; i < 200 && q.size() < n; i++) step();
    if (q.size() < n) check("wait_q_timeout", q.size(), n);
  endtask

  task automatic wait_rv();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_valid) break;
    end
    if (!req_valid) check("wait_req_timeout", {31'b0, req_valid}, 32'd1);
  endtask

  task automatic wait_hs();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_valid && req_ready) break;
    end
    if (!(req_valid && req_ready)) check("wait_hs_timeout", {31'b0, req_valid}, 32'd1);
    step();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  // Memory: one response, lat cycles after each accepted request.
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (!rst && req_valid && req_ready) begin
        a = req_addr;
        repeat (lat) @(posedge clk);
        #1;
        rsp_valid = 1'b1;
        rsp_data  = data_of(a);
        rsp_err   = (a == err_addr);
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) q.push_back({inst_pc, inst, inst_err});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int cnt;

    // Reset
    step();
    step();
    @(negedge clk);
    check("rst_req_valid", {31'b0, req_valid}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", {31'b0, req_valid}, 32'd1);
    check("first_req_addr", req_addr, 32'h8000_0000);
    step();

    // 1: sequential fetch
    wait_q(3);
    for (int i = 0; i < 3; i++) begin
      check("t1_pc", q[i].pc, 32'h8000_0000 + 32'(4 * i));
      check("t1_data", q[i].data, data_of(32'h8000_0000 + 32'(4 * i)));
    end

    // 2: back-pressure fills exactly FIFO_DEPTH entries
    inst_ready = 1'b0;
    repeat (20) step();
    @(negedge clk);
    check("t2_stall_req_valid", {31'b0, req_valid}, 32'd0);
    check("t2_stall_inst_valid", {31'b0, inst_valid}, 32'd1);
    n0 = q.size();
    step();
    req_ready  = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!inst_valid) break;
    end
    check("t2_buffered", q.size() - n0, 32'd4);
    step();
    req_ready = 1'b1;
    wait_q(n0 + 7);
    for (int i = 0; i < q.size(); i++) begin
      check("t2_seq_pc", q[i].pc, 32'h8000_0000 + 32'(4 * i));
      check("t2_seq_data", q[i].data, data_of(32'h8000_0000 + 32'(4 * i)));
      check("t2_seq_err", {31'b0, q[i].err}, 32'd0);
    end
    q.delete();

    // 3: redirect while waiting on a slow response
    lat = 3;
    inst_ready = 1'b0;
    wait_hs();
    wait_hs();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    @(negedge clk);
    check("t3_pre_inst_valid", {31'b0, inst_valid}, 32'd1);
    step();
    redirect_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    check("t3_flush_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("t3_drop_req_valid", {31'b0, req_valid}, 32'd0);
    wait_rv();
    check("t3_new_addr", req_addr, 32'h8000_0100);
    step();
    inst_ready = 1'b1;
    wait_q(3);
    for (int i = 0; i < 3; i++) begin
      check("t3_pc", q[i].pc, 32'h8000_0100 + 32'(4 * i));
      check("t3_data", q[i].data, data_of(32'h8000_0100 + 32'(4 * i)));
    end

    // 4: access fault halts fetch
    err_addr = 32'h8000_0010;
    redirect(32'h8000_0000);
    q.delete();
    wait_q(5);
    check("t4_first_pc", q[0].pc, 32'h8000_0000);
    check("t4_ok_err", {31'b0, q[3].err}, 32'd0);
    check("t4_err_pc", q[4].pc, 32'h8000_0010);
    check("t4_err_flag", {31'b0, q[4].err}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_valid) cnt++;
      step();
    end
    check("t4_halt_no_req", cnt, 32'd0);
    check("t4_halt_entries", q.size(), 32'd5);

    // 5: request held stable while not ready
    req_ready = 1'b0;
    err_addr  = 32'h0000_0001;
    redirect(32'h8000_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_req_valid", {31'b0, req_valid}, 32'd1);
      check("t5_req_addr", req_addr, 32'h8000_0000);
      step();
    end
    req_ready = 1'b1;

    // 6: fetch address wraps
    redirect(32'hffff_fffc);
    q.delete();
    wait_rv();
    check("t6_addr_top", req_addr, 32'hffff_fffc);
    step();
    wait_rv();
    check("t6_addr_wrap", req_addr, 32'h0000_0000);
    step();
    wait_q(1);
    check("t6_pop_pc", q[0].pc, 32'hffff_fffc);
    check("t6_pop_data", q[0].data, data_of(32'hffff_fffc));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
